// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: byte width and the
// sequencing-controller state encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        ARM     = 2'd1,
        RUN     = 2'd2,
        RECOVER = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received bytes. Pointers carry one extra
// wrap bit so full and empty can be told apart. The head is read
// combinationally so a pop exposes the next byte on the following cycle.
// Flush empties the FIFO and wins over push and pop.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [UART_DATA_W-1:0] din,
    output logic [UART_DATA_W-1:0] dout,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            level
);

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [AW:0]            wr_ptr_reg;
    logic [AW:0]            rd_ptr_reg;
    logic                   do_pop;

    assign empty  = (wr_ptr_reg == rd_ptr_reg);
    assign full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign level  = wr_ptr_reg - rd_ptr_reg;
    assign do_pop = pop && !empty;
    // An empty FIFO presents zero rather than a stale entry.
    assign dout   = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    // Storage write; the caller only pushes when a slot is free this cycle.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    // Pointer update with flush taking priority.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencing controller. Sequences the receive FSM enable and
// sync reset, buffers completed frames in uart_rx_fifo, streams them to the
// host and keeps framing-error / overrun status.
// Optional parity-error accounting is enabled with UART_RX_CTRL_PARITY_EN.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int AW          = 2,
    parameter int ERR_W       = 8,
    parameter int RECOVER_CYC = 2
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   cfg_en,
    input  logic                   cfg_flush,
    input  logic                   rx_busy,
    input  logic                   rx_done,
    input  logic                   rx_err,
    input  logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_en,
    output logic                   rx_rst,
    output logic                   m_valid,
    output logic [UART_DATA_W-1:0] m_data,
    input  logic                   m_ready,
    output logic [AW:0]            fifo_level,
    output logic                   overrun,
    output logic [ERR_W-1:0]       err_cnt
`ifdef UART_RX_CTRL_PARITY_EN
    ,
    input  logic                   rx_par_err,
    output logic [ERR_W-1:0]       par_cnt
`endif
);

    localparam int RCW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

    rx_state_e        state_reg, state_next;
    logic [RCW-1:0]   rec_cnt_reg;
    logic [ERR_W-1:0] err_cnt_reg;
    logic             overrun_reg;
    logic             fifo_full, fifo_empty;
    logic             in_run, frame_ok, par_ok, pop, push;

    assign in_run   = (state_reg == RUN);
    // A frame is only captured while running and when its framing was good.
    assign frame_ok = in_run && rx_done && !rx_err && par_ok;
    assign pop      = m_valid && m_ready;
    // A full FIFO still accepts when the host drains a slot in the same cycle.
    assign push     = frame_ok && !cfg_flush && (!fifo_full || pop);
    assign m_valid  = !fifo_empty;
    assign overrun  = overrun_reg;
    assign err_cnt  = err_cnt_reg;

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk    (clk),
        .arst_n (arst_n),
        .push   (push),
        .pop    (pop),
        .flush  (cfg_flush),
        .din    (rx_data),
        .dout   (m_data),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_reg <= OFF;
        else         state_reg <= state_next;
    end

    // Next state and receive-FSM control; flush forces a restart via RECOVER.
    always_comb begin
        state_next = state_reg;
        rx_en      = 1'b0;
        rx_rst     = 1'b1;
        case (state_reg)
            OFF: begin
                if (cfg_en) state_next = ARM;
            end
            ARM: begin
                rx_en      = 1'b1;
                rx_rst     = 1'b0;
                state_next = RUN;
            end
            RUN: begin
                rx_en  = 1'b1;
                rx_rst = 1'b0;
                if (rx_err) begin
                    state_next = RECOVER;
                end else if (!cfg_en && (!rx_busy || rx_done)) begin
                    // Let an in-flight frame finish before switching off.
                    state_next = OFF;
                end
            end
            RECOVER: begin
                if (rec_cnt_reg == RCW'(RECOVER_CYC - 1)) begin
                    state_next = cfg_en ? ARM : OFF;
                end
            end
            default: state_next = OFF;
        endcase
        if (cfg_flush) state_next = RECOVER;
    end

    // Cycles spent in RECOVER; restarts on entry and on every flush.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)                                rec_cnt_reg <= '0;
        else if (cfg_flush || state_reg != RECOVER) rec_cnt_reg <= '0;
        else                                        rec_cnt_reg <= rec_cnt_reg + 1'b1;
    end

    // Saturating framing-error counter.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)                                    err_cnt_reg <= '0;
        else if (cfg_flush)                             err_cnt_reg <= '0;
        else if (in_run && rx_err && err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + ERR_W'(1);
    end

    // Sticky overrun: a good frame found no room in the FIFO.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)                            overrun_reg <= 1'b0;
        else if (cfg_flush)                     overrun_reg <= 1'b0;
        else if (frame_ok && fifo_full && !pop) overrun_reg <= 1'b1;
    end

`ifdef UART_RX_CTRL_PARITY_EN
    logic [ERR_W-1:0] par_cnt_reg;

    assign par_ok  = !rx_par_err;
    assign par_cnt = par_cnt_reg;

    // Saturating parity-error counter; framing was valid so no RECOVER.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)        par_cnt_reg <= '0;
        else if (cfg_flush) par_cnt_reg <= '0;
        else if (in_run && rx_done && !rx_err && rx_par_err && par_cnt_reg != '1)
            par_cnt_reg <= par_cnt_reg + ERR_W'(1);
    end
`else
    assign par_ok = 1'b1;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed, table-driven bench for uart_rx_ctrl (DEPTH=4, ERR_W=8,
// RECOVER_CYC=2). Each vector drives inputs for one clock and lists the
// outputs expected just after that edge.
module tb_uart_rx_ctrl;

    logic       clk;
    logic       arst_n;
    logic       cfg_en, cfg_flush, rx_busy, rx_done, rx_err, m_ready;
    logic [7:0] rx_data;
    logic       rx_en, rx_rst, m_valid, overrun;
    logic [7:0] m_data;
    logic [2:0] fifo_level;
    logic [7:0] err_cnt;
`ifdef UART_RX_CTRL_PARITY_EN
    logic       rx_par_err;
    logic [7:0] par_cnt;
`endif

    uart_rx_ctrl #(
        .DEPTH(4), .AW(2), .ERR_W(8), .RECOVER_CYC(2)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .cfg_en     (cfg_en),
        .cfg_flush  (cfg_flush),
        .rx_busy    (rx_busy),
        .rx_done    (rx_done),
        .rx_err     (rx_err),
        .rx_data    (rx_data),
        .rx_en      (rx_en),
        .rx_rst     (rx_rst),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .fifo_level (fifo_level),
        .overrun    (overrun),
        .err_cnt    (err_cnt)
`ifdef UART_RX_CTRL_PARITY_EN
        ,
        .rx_par_err (rx_par_err),
        .par_cnt    (par_cnt)
`endif
    );

    typedef struct {
        logic       en, fl, busy, done, err;
        logic [7:0] data;
        logic       rdy;
        logic       e_en, e_rst, e_mv;
        logic [7:0] e_md;
        logic [2:0] e_lvl;
        logic       e_ovr;
        logic [7:0] e_err;
    } vec_t;

    vec_t vq[$];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input logic en, fl, busy, done, err,
                               input logic [7:0] data, input logic rdy,
                               input logic e_en, e_rst, e_mv,
                               input logic [7:0] e_md, input logic [2:0] e_lvl,
                               input logic e_ovr, input logic [7:0] e_err);
        vec_t r;
        r.en = en; r.fl = fl; r.busy = busy; r.done = done; r.err = err;
        r.data = data; r.rdy = rdy;
        r.e_en = e_en; r.e_rst = e_rst; r.e_mv = e_mv; r.e_md = e_md;
        r.e_lvl = e_lvl; r.e_ovr = e_ovr; r.e_err = e_err;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, fl, busy, done, err, input logic [7:0] data, input logic rdy);
        cfg_en = en; cfg_flush = fl; rx_busy = busy; rx_done = done;
        rx_err = err; rx_data = data; m_ready = rdy;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 8'h00, 0);
`ifdef UART_RX_CTRL_PARITY_EN
        rx_par_err = 1'b0;
`endif
        arst_n = 1'b0;

        //      en fl bs dn er data   rdy  rx_en rst mv  m_data lvl ovr err
        vq.push_back(v(1,0,0,0,0,8'h00,0, 1,0,0,8'h00,3'd0,0,8'd0)); // 0 ARM
        vq.push_back(v(1,0,0,0,0,8'h00,0, 1,0,0,8'h00,3'd0,0,8'd0)); // 1 RUN
        vq.push_back(v(1,0,0,1,0,8'h55,0, 1,0,1,8'h55,3'd1,0,8'd0)); // 2
        vq.push_back(v(1,0,0,1,0,8'hA3,0, 1,0,1,8'h55,3'd2,0,8'd0)); // 3
        vq.push_back(v(1,0,0,1,0,8'h0F,0, 1,0,1,8'h55,3'd3,0,8'd0)); // 4
        vq.push_back(v(1,0,0,0,0,8'h00,0, 1,0,1,8'h55,3'd3,0,8'd0)); // 5 hold
        vq.push_back(v(1,0,0,0,0,8'h00,1, 1,0,1,8'hA3,3'd2,0,8'd0)); // 6 drain
        vq.push_back(v(1,0,0,0,0,8'h00,1, 1,0,1,8'h0F,3'd1,0,8'd0)); // 7
        vq.push_back(v(1,0,0,0,0,8'h00,1, 1,0,0,8'h00,3'd0,0,8'd0)); // 8
        vq.push_back(v(1,0,0,0,0,8'h00,0, 1,0,0,8'h00,3'd0,0,8'd0)); // 9
        vq.push_back(v(1,0,0,1,0,8'h01,0, 1,0,1,8'h01,3'd1,0,8'd0)); // 10 fill
        vq.push_back(v(1,0,0,1,0,8'h02,0, 1,0,1,8'h01,3'd2,0,8'd0)); // 11
        vq.push_back(v(1,0,0,1,0,8'h03,0, 1,0,1,8'h01,3'd3,0,8'd0)); // 12
        vq.push_back(v(1,0,0,1,0,8'h04,0, 1,0,1,8'h01,3'd4,0,8'd0)); // 13 full
        vq.push_back(v(1,0,0,1,0,8'h05,0, 1,0,1,8'h01,3'd4,1,8'd0)); // 14 overrun
        vq.push_back(v(1,0,0,0,0,8'h00,1, 1,0,1,8'h02,3'd3,1,8'd0)); // 15
        vq.push_back(v(1,0,0,0,0,8'h00,1, 1,0,1,8'h03,3'd2,1,8'd0)); // 16
        vq.push_back(v(1,0,0,0,0,8'h00,1, 1,0,1,8'h04,3'd1,1,8'd0)); // 17
        vq.push_back(v(1,0,0,0,0,8'h00,1, 1,0,0,8'h00,3'd0,1,8'd0)); // 18 0x05 absent
        vq.push_back(v(1,1,0,0,0,8'h00,0, 0,1,0,8'h00,3'd0,0,8'd0)); // 19 flush
        vq.push_back(v(1,0,0,0,0,8'h00,0, 0,1,0,8'h00,3'd0,0,8'd0)); // 20 RECOVER
        vq.push_back(v(1,0,0,0,0,8'h00,0, 1,0,0,8'h00,3'd0,0,8'd0)); // 21 ARM
        vq.push_back(v(1,0,0,0,0,8'h00,0, 1,0,0,8'h00,3'd0,0,8'd0)); // 22 RUN
        vq.push_back(v(1,0,0,1,0,8'h11,0, 1,0,1,8'h11,3'd1,0,8'd0)); // 23
        vq.push_back(v(1,0,0,1,0,8'h22,0, 1,0,1,8'h11,3'd2,0,8'd0)); // 24
        vq.push_back(v(1,0,0,1,0,8'h33,0, 1,0,1,8'h11,3'd3,0,8'd0)); // 25
        vq.push_back(v(1,0,0,1,0,8'h44,0, 1,0,1,8'h11,3'd4,0,8'd0)); // 26 full
        vq.push_back(v(1,0,0,1,0,8'h55,1, 1,0,1,8'h22,3'd4,0,8'd0)); // 27 push+pop
        vq.push_back(v(1,0,0,0,0,8'h00,1, 1,0,1,8'h33,3'd3,0,8'd0)); // 28
        vq.push_back(v(1,0,0,0,0,8'h00,1, 1,0,1,8'h44,3'd2,0,8'd0)); // 29
        vq.push_back(v(1,0,0,0,0,8'h00,1, 1,0,1,8'h55,3'd1,0,8'd0)); // 30
        vq.push_back(v(1,0,0,0,0,8'h00,1, 1,0,0,8'h00,3'd0,0,8'd0)); // 31
        vq.push_back(v(1,0,0,0,1,8'h00,0, 0,1,0,8'h00,3'd0,0,8'd1)); // 32 rx_err
        vq.push_back(v(1,0,0,0,0,8'h00,0, 0,1,0,8'h00,3'd0,0,8'd1)); // 33
        vq.push_back(v(1,0,0,0,0,8'h00,0, 1,0,0,8'h00,3'd0,0,8'd1)); // 34 ARM
        vq.push_back(v(1,0,0,0,0,8'h00,0, 1,0,0,8'h00,3'd0,0,8'd1)); // 35 RUN
        vq.push_back(v(1,0,0,1,1,8'hAA,0, 0,1,0,8'h00,3'd0,0,8'd2)); // 36 done+err
        vq.push_back(v(1,0,0,0,0,8'h00,0, 0,1,0,8'h00,3'd0,0,8'd2)); // 37
        vq.push_back(v(1,0,0,0,0,8'h00,0, 1,0,0,8'h00,3'd0,0,8'd2)); // 38
        vq.push_back(v(1,0,0,0,0,8'h00,0, 1,0,0,8'h00,3'd0,0,8'd2)); // 39
        vq.push_back(v(1,0,0,1,0,8'h5A,0, 1,0,1,8'h5A,3'd1,0,8'd2)); // 40
        vq.push_back(v(1,1,0,1,0,8'h66,0, 0,1,0,8'h00,3'd0,0,8'd0)); // 41 flush+done
        vq.push_back(v(1,0,0,0,0,8'h00,0, 0,1,0,8'h00,3'd0,0,8'd0)); // 42
        vq.push_back(v(1,0,0,0,0,8'h00,0, 1,0,0,8'h00,3'd0,0,8'd0)); // 43
        vq.push_back(v(1,0,0,0,0,8'h00,0, 1,0,0,8'h00,3'd0,0,8'd0)); // 44
        vq.push_back(v(0,0,1,0,0,8'h00,0, 1,0,0,8'h00,3'd0,0,8'd0)); // 45 busy hold
        vq.push_back(v(0,0,1,0,0,8'h00,0, 1,0,0,8'h00,3'd0,0,8'd0)); // 46
        vq.push_back(v(0,0,1,1,0,8'h7E,0, 0,1,1,8'h7E,3'd1,0,8'd0)); // 47 capture, OFF
        vq.push_back(v(0,0,0,0,0,8'h00,1, 0,1,0,8'h00,3'd0,0,8'd0)); // 48
        vq.push_back(v(1,0,0,0,0,8'h00,0, 1,0,0,8'h00,3'd0,0,8'd0)); // 49 ARM
        vq.push_back(v(1,0,0,0,0,8'h00,0, 1,0,0,8'h00,3'd0,0,8'd0)); // 50 RUN
        vq.push_back(v(0,0,0,0,0,8'h00,0, 0,1,0,8'h00,3'd0,0,8'd0)); // 51 idle off
        vq.push_back(v(0,0,0,1,0,8'h99,0, 0,1,0,8'h00,3'd0,0,8'd0)); // 52 OFF ignores

        // Reset state while reset is asserted.
        #8;
        check("rst.rx_en",   {31'd0, rx_en},      32'd0);
        check("rst.rx_rst",  {31'd0, rx_rst},     32'd1);
        check("rst.m_valid", {31'd0, m_valid},    32'd0);
        check("rst.m_data",  {24'd0, m_data},     32'd0);
        check("rst.level",   {29'd0, fifo_level}, 32'd0);
        check("rst.overrun", {31'd0, overrun},    32'd0);
        check("rst.err_cnt", {24'd0, err_cnt},    32'd0);
        #4;
        arst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].en, vq[i].fl, vq[i].busy, vq[i].done, vq[i].err, vq[i].data, vq[i].rdy);
            step();
            check($sformatf("v%0d.rx_en", i),   {31'd0, rx_en},      {31'd0, vq[i].e_en});
            check($sformatf("v%0d.rx_rst", i),  {31'd0, rx_rst},     {31'd0, vq[i].e_rst});
            check($sformatf("v%0d.m_valid", i), {31'd0, m_valid},    {31'd0, vq[i].e_mv});
            check($sformatf("v%0d.m_data", i),  {24'd0, m_data},     {24'd0, vq[i].e_md});
            check($sformatf("v%0d.level", i),   {29'd0, fifo_level}, {29'd0, vq[i].e_lvl});
            check($sformatf("v%0d.overrun", i), {31'd0, overrun},    {31'd0, vq[i].e_ovr});
            check($sformatf("v%0d.err_cnt", i), {24'd0, err_cnt},    {24'd0, vq[i].e_err});
            $display("vec %0d: rx_en=%0b rx_rst=%0b m_valid=%0b m_data=%02h level=%0d overrun=%0b err_cnt=%0d",
                     i, rx_en, rx_rst, m_valid, m_data, fifo_level, overrun, err_cnt);
        end

        // Error counter saturation: each error costs RUN -> 2x RECOVER -> ARM -> RUN.
        drive(1, 0, 0, 0, 0, 8'h00, 0);
        step();
        step();
        for (int n = 1; n <= 260; n++) begin
            if (n == 260) check("sat.in_run", {31'd0, rx_en}, 32'd1);
            rx_err = 1'b1;
            step();
            rx_err = 1'b0;
            if (n == 1 || n == 254 || n == 255 || n == 260) begin
                check($sformatf("sat.err_cnt@%0d", n), {24'd0, err_cnt},
                      (n >= 255) ? 32'd255 : n);
                $display("sat %0d errors: err_cnt=%0d", n, err_cnt);
            end
            step();
            step();
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Sequencing controller for the UART receive path. It drives the receive FSM's enable and synchronous reset, and captures each completed frame from the SIPO into a small FIFO. It presents the buffered bytes to the host over a valid/ready stream and tracks framing errors and overruns. It sits between the UART RX FSM/SIPO pair and the bus-side register block.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
AW, 2, FIFO address width, equal to log2(DEPTH)
ERR_W, 8, width of the saturating framing-error counter
RECOVER_CYC, 2, clk cycles the receive FSM is held in sync reset after an error or flush

Ports:
clk  in  1  system clock
arst_n  in  1  asynchronous active-low reset
cfg_en  in  1  receive enable from the register block
cfg_flush  in  1  single-cycle pulse; empties the FIFO and restarts the receive FSM
rx_busy  in  1  busy flag from the receive FSM
rx_done  in  1  single-cycle frame-complete pulse from the receive FSM
rx_err  in  1  single-cycle stop-bit framing error pulse from the receive FSM
rx_data  in  8  parallel byte from the SIPO; valid in the cycle rx_done is high
rx_en  out  1  enable to the receive FSM
rx_rst  out  1  synchronous reset to the receive FSM, active high
m_valid  out  1  stream valid to the host
m_data  out  8  stream data, equal to the FIFO head
m_ready  in  1  stream ready from the host
fifo_level  out  AW+1  number of occupied FIFO entries, 0..DEPTH
overrun  out  1  sticky flag; a frame arrived while the FIFO was full; cleared by cfg_flush
err_cnt  out  ERR_W  saturating count of framing errors; cleared by cfg_flush

Behaviour:
- Reset (arst_n low, asynchronous):
  - state=OFF; FIFO empty; rx_en=0, rx_rst=1, m_valid=0, m_data=0, fifo_level=0, overrun=0, err_cnt=0.
- States: OFF, ARM, RUN, RECOVER.
  - OFF: rx_en=0, rx_rst=1. Go to ARM when cfg_en=1.
  - ARM: rx_en=1, rx_rst=0, for exactly one cycle. Then go to RUN.
  - RUN: rx_en=1, rx_rst=0.
    - cfg_en=0 with rx_busy=0: go to OFF next cycle.
    - cfg_en=0 with rx_busy=1: stay in RUN until rx_done or rx_err, then go to OFF. An in-flight frame is never truncated.
    - rx_err: err_cnt+1, saturating at all-ones; go to RECOVER. The byte is not written to the FIFO.
  - RECOVER: rx_en=0, rx_rst=1 for RECOVER_CYC cycles, counted by an internal counter. Then go to ARM if cfg_en=1, else OFF.
- cfg_flush has priority over everything except reset:
  - FIFO pointers cleared, overrun and err_cnt cleared, next state RECOVER.
  - A rx_done in the same cycle is discarded.
- Capture:
  - rx_done in RUN with FIFO not full: rx_data written at the write pointer in that cycle; m_valid rises the next cycle. Capture latency is 1 clk.
  - rx_done with FIFO full: byte dropped, overrun set to 1.
  - rx_done and rx_err asserted together: treated as an error; no write.
- Stream:
  - Transfer when m_valid and m_ready are both high; the read pointer advances that cycle.
  - m_data holds stable while m_valid=1 and m_ready=0.
  - m_valid = (fifo_level != 0).
- Pointers are AW+1 bits and wrap naturally.
  - full: MSBs differ and the low AW bits are equal.
  - empty: pointers equal.
- Simultaneous write and read:
  - FIFO full: the read frees a slot, so the write succeeds and overrun is not set.
  - FIFO empty: the write is not visible to the read in the same cycle (no bypass).
- fifo_level updates one cycle after the corresponding push or pop event.

Optional Feature:
- Macro UART_RX_CTRL_PARITY_EN.
- Defined:
  - Adds input rx_par_err (1 bit, qualified by rx_done) and output par_cnt (ERR_W bits, saturating).
  - A frame with rx_par_err=1 increments par_cnt and is not written to the FIFO.
  - No RECOVER entry, because the framing was valid.
  - par_cnt is cleared by cfg_flush.
- Undefined: port and counter are absent, and every rx_done is captured subject to FIFO space.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams OFF=2'd0, ARM=2'd1, RUN=2'd2, RECOVER=2'd3;
  - UART_DATA_W=8.
- One sub-module, uart_rx_fifo (synchronous FIFO, DEPTH x 8):
  - ports push, pop, flush, din, dout, full, empty, level.
  - The controller keeps the FSM, the counters and the overrun logic.

Test Plan:
- Reset, then cfg_en=1 -> ARM for 1 cycle, then RUN; rx_en=1 and rx_rst=0 from the cycle after ARM is entered.
- Three rx_done pulses with 0x55, 0xA3, 0x0F, m_ready=0 -> fifo_level=3; then m_ready=1 -> m_data sequence 0x55, 0xA3, 0x0F on consecutive cycles, m_valid=0 afterwards.
- Five rx_done pulses with DEPTH=4 and m_ready=0 -> fifo_level=4, overrun=1, head 0x01 retained; the fifth byte is absent from the output stream.
- rx_err pulse in RUN -> err_cnt=1, rx_rst=1 for exactly 2 cycles, rx_en=0 during RECOVER, back to RUN via ARM; 256 errors with ERR_W=8 -> err_cnt stays 0xFF.
- cfg_en dropped while rx_busy=1, then rx_done with 0x7E -> 0x7E captured, then OFF; cfg_en dropped while idle -> OFF in the next cycle.
- FIFO full and m_ready=1 with rx_done in the same cycle -> write accepted, overrun remains 0, fifo_level remains 4; cfg_flush together with rx_done -> fifo_level=0, err_cnt=0, overrun=0, state RECOVER.
